// File: rtl/vga_capture.sv
// VGA receive-side timing checker and 1bpp frame grabber.
// Tracks beam position from the syncs and writes one pixel-doubled frame into a byte buffer on request.
module vga_capture #(
  parameter int H_TOTAL  = 800,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 71,
  parameter int V_ACTIVE = 408
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [3:0]  color_in,
  input  logic [1:0]  cpu_addr,
  input  logic [7:0]  cpu_dbw,
  input  logic        cpu_we,
  output logic [7:0]  cpu_dbr,
  output logic [12:0] buf_addr,
  output logic [7:0]  buf_data,
  output logic        buf_we
);
  localparam logic [9:0]  H_MAX     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_LO      = 10'(H_START);
  localparam logic [9:0]  H_HI      = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_MAX     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LO      = 10'(V_START);
  localparam logic [9:0]  V_HI      = 10'(V_START + V_ACTIVE);
  localparam logic [12:0] LAST_ADDR = 13'((H_ACTIVE / 16) * (V_ACTIVE / 2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       error;
    logic       done;
    logic       busy;
    logic       locked;
  } status_t;

  state_t     state, state_nx;
  logic       hs_r, hs_p, vs_r, vs_p;
  logic [3:0] col_r;
  logic [9:0] hcount, vcount;
  logic       hs_fall, vs_fall, line_err, frame_err, tm_err;
  logic       locked, seen_good, error, done, busy;
  logic [7:0] errcnt;
  logic [3:0] match;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       we_q, arm, sample, pix, cap_ok;
  status_t    status;
  logic       unused_dbw;

  assign unused_dbw = ^cpu_dbw[7:4];

  // One register stage on every video input; all timing uses these copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r  <= 1'b1;
      hs_p  <= 1'b1;
      vs_r  <= 1'b1;
      vs_p  <= 1'b1;
      col_r <= '0;
    end else begin
      hs_r  <= hsync_in;
      hs_p  <= hs_r;
      vs_r  <= vsync_in;
      vs_p  <= vs_r;
      col_r <= color_in;
    end
  end

  assign hs_fall   = hs_p & ~hs_r;
  assign vs_fall   = vs_p & ~vs_r;
  assign line_err  = hs_fall && (hcount != H_MAX);
  assign frame_err = vs_fall && (vcount != V_MAX);
  assign tm_err    = line_err | frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      if (hs_fall || hcount == H_MAX) hcount <= '0;
      else                            hcount <= hcount + 10'd1;
      if (vs_fall)      vcount <= '0;
      else if (hs_fall) vcount <= vcount + 10'd1;
    end
  end

  // Lock needs two consecutive good line ends; any timing error drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked    <= 1'b0;
      seen_good <= 1'b0;
      errcnt    <= '0;
    end else begin
      if (tm_err) begin
        locked    <= 1'b0;
        seen_good <= 1'b0;
        if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
      end else if (hs_fall) begin
        seen_good <= 1'b1;
        if (seen_good) locked <= 1'b1;
      end
    end
  end

  assign sample = (vcount >= V_LO) && (vcount < V_HI) && (vcount[0] == V_LO[0]) &&
                  (hcount >= H_LO) && (hcount < H_HI) && (hcount[0] == H_LO[0]);
  assign pix    = (col_r == match);
  assign arm    = cpu_we && (cpu_addr == 2'd1) && cpu_dbw[0];
  assign cap_ok = (state == S_CAP) && !tm_err;
  assign done   = (state == S_DONE);
  assign busy   = (state == S_WAIT) || (state == S_CAP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (arm) state_nx = S_WAIT;
      S_WAIT: if (vs_fall && locked && !frame_err) state_nx = S_CAP;
      S_CAP: begin
        if (tm_err)                               state_nx = S_IDLE;
        else if (we_q && buf_addr == LAST_ADDR)   state_nx = S_DONE;
      end
      S_DONE: if (arm) state_nx = S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match    <= 4'hF;
      error    <= 1'b0;
      bitcnt   <= '0;
      shreg    <= '0;
      we_q     <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      we_q <= 1'b0;
      if (cpu_we && cpu_addr == 2'd0) match <= cpu_dbw[3:0];
      if (state == S_CAP && tm_err)        error <= 1'b1;
      else if (state == S_DONE && arm)     error <= 1'b0;
      if (state == S_WAIT && state_nx == S_CAP) begin
        buf_addr <= '0;
        bitcnt   <= '0;
      end else if (we_q) begin
        buf_addr <= buf_addr + 13'd1;
      end
      // Pixels enter at the MSB so the first pixel of a byte ends up in bit 0.
      if (cap_ok && sample) begin
        shreg  <= {pix, shreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          buf_data <= {pix, shreg[7:1]};
          we_q     <= 1'b1;
        end
      end
    end
  end

  // Masking with rst keeps a pending strobe off the bus on the reset clock itself.
  assign buf_we = we_q & ~rst;

  assign status = '{rsvd: 4'b0, error: error, done: done, busy: busy, locked: locked};

  always_comb begin
    cpu_dbr = '0;
    case (cpu_addr)
      2'd0:    cpu_dbr = {4'b0, match};
      2'd2:    cpu_dbr = status;
      2'd3:    cpu_dbr = errcnt;
      default: cpu_dbr = '0;
    endcase
  end
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 100x20 raster (4 bytes x 8 rows = 32 writes per frame).
module tb_vga_capture;
  localparam int H_T = 100, H_S = 20, H_A = 64, V_T = 20, V_S = 3, V_A = 16;
  localparam int NWR = 32;
  localparam int EARLY_LINE = 12;

  logic        clk = 0, rst = 1;
  logic        hsync_in, vsync_in;
  logic [3:0]  color_in;
  logic [1:0]  cpu_addr = 2'd2;
  logic [7:0]  cpu_dbw = '0;
  logic        cpu_we = 0;
  logic [7:0]  cpu_dbr;
  logic [12:0] buf_addr;
  logic [7:0]  buf_data;
  logic        buf_we;

  vga_capture #(.H_TOTAL(H_T), .H_START(H_S), .H_ACTIVE(H_A),
                .V_TOTAL(V_T), .V_START(V_S), .V_ACTIVE(V_A)) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .color_in(color_in),
    .cpu_addr(cpu_addr), .cpu_dbw(cpu_dbw), .cpu_we(cpu_we), .cpu_dbr(cpu_dbr),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit sync_en = 0;
  int pat = 0;
  int short_cnt = 0, short_done = 0, early_cnt = 0, early_done = 0;
  int hp, vp;

  int          wr_cnt = 0;
  logic [12:0] log_addr [1024];
  logic [7:0]  log_data [1024];
  int          log_vp   [1024];

  // Video source: pattern 0 = white block on line V_S, pattern 1 = F/1 alternating every 2 clocks.
  initial begin
    hp = 0; vp = 0;
    hsync_in = 1; vsync_in = 1; color_in = 4'h1;
    forever begin
      @(posedge clk); #1;
      hsync_in = !(sync_en && hp < 12);
      vsync_in = !(sync_en && vp < 2);
      if (pat == 0) color_in = (vp == V_S && hp >= 20 && hp < 36) ? 4'hF : 4'h1;
      else          color_in = hp[1] ? 4'h1 : 4'hF;
      if (hp == H_T - 1 || (hp == H_T - 2 && short_cnt != short_done)) begin
        if (hp == H_T - 2) short_done++;
        hp = 0;
        if (early_cnt != early_done && vp == EARLY_LINE) begin
          vp = 0;
          early_done++;
        end else begin
          vp = (vp == V_T - 1) ? 0 : vp + 1;
        end
      end else begin
        hp++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (buf_we === 1'b1) begin
        log_addr[wr_cnt & 1023] = buf_addr;
        log_data[wr_cnt & 1023] = buf_data;
        log_vp[wr_cnt & 1023]   = vp;
        wr_cnt++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cpu_addr = a; #1;
    d = cpu_dbr;
    cpu_addr = 2'd2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    tick();
    cpu_addr = a; cpu_dbw = d; cpu_we = 1;
    tick();
    cpu_we = 0; cpu_addr = 2'd2;
  endtask

  task automatic wait_stat(input logic [7:0] mask, input logic [7:0] val, input int maxc,
                           input string name);
    logic [7:0] s;
    rd(2'd2, s);
    for (int i = 0; i < maxc && (s & mask) != val; i++) begin
      tick();
      rd(2'd2, s);
    end
    chk(name, s & mask, val);
  endtask

  task automatic wait_wr(input int n, input int maxc, input string name);
    for (int i = 0; i < maxc && wr_cnt < n; i++) tick();
    chk(name, int'(wr_cnt >= n), 1);
  endtask

  task automatic chk_frame(input int base, input string name, input bit all55);
    int bad_addr = 0, bad_data = 0, bad_row = 0;
    chk({name, "_count"}, wr_cnt - base, NWR);
    for (int i = 0; i < NWR; i++) begin
      if (log_addr[(base + i) & 1023] != 13'(i)) bad_addr++;
      if (all55 && log_data[(base + i) & 1023] != 8'h55) bad_data++;
      if (((log_vp[(base + i) & 1023] - V_S) % 2) != 0) bad_row++;
    end
    chk({name, "_addr_seq"}, bad_addr, 0);
    chk({name, "_odd_row_writes"}, bad_row, 0);
    if (all55) chk({name, "_data55"}, bad_data, 0);
  endtask

  typedef struct {
    bit         do_wr;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] s, e1, e2;
    int base, w1, w_rst, nz;
    bit found;

    vecs[0] = '{0, 2'd0, 8'h00, 2'd0, 8'h0F, "rst_match"};
    vecs[1] = '{0, 2'd0, 8'h00, 2'd1, 8'h00, "rst_rd1"};
    vecs[2] = '{0, 2'd0, 8'h00, 2'd2, 8'h00, "rst_status"};
    vecs[3] = '{0, 2'd0, 8'h00, 2'd3, 8'h00, "rst_errcnt"};
    vecs[4] = '{1, 2'd0, 8'hA5, 2'd0, 8'h05, "match_wr_a5"};
    vecs[5] = '{1, 2'd0, 8'hF3, 2'd0, 8'h03, "match_wr_f3"};
    vecs[6] = '{1, 2'd1, 8'h00, 2'd2, 8'h00, "arm_bit0_clear"};
    vecs[7] = '{1, 2'd1, 8'hFE, 2'd1, 8'h00, "rd1_zero"};
    vecs[8] = '{1, 2'd1, 8'hFE, 2'd2, 8'h00, "arm_upper_bits"};
    vecs[9] = '{1, 2'd0, 8'h0F, 2'd0, 8'h0F, "match_restore"};

    // Reset state and register file
    repeat (5) tick();
    chk("rst_buf_we", buf_we, 0);
    chk("rst_buf_addr", buf_addr, 0);
    chk("rst_buf_data", buf_data, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].wa, vecs[i].wd);
      rd(vecs[i].ra, s);
      chk(vecs[i].name, s, vecs[i].exp);
    end

    // Capture the white block: first byte FF, everything else 00
    sync_en = 1;
    repeat (4000) tick();
    rd(2'd2, s); chk("t1_locked", s, 8'h01);
    base = wr_cnt;
    wr(2'd1, 8'h01);
    rd(2'd2, s); chk("t1_busy", s, 8'h03);
    wait_stat(8'h04, 8'h04, 6000, "t1_done_seen");
    rd(2'd2, s); chk("t1_status", s, 8'h05);
    chk_frame(base, "t1", 0);
    chk("t1_byte0", log_data[base & 1023], 8'hFF);
    chk("t1_byte1", log_data[(base + 1) & 1023], 8'h00);
    nz = 0;
    for (int i = 0; i < NWR; i++) if (log_data[(base + i) & 1023] != 8'h00) nz++;
    chk("t1_nonzero_bytes", nz, 1);

    // Alternating pattern, re-arm from DONE, arm mid-capture must be ignored
    pat = 1;
    base = wr_cnt;
    wr(2'd1, 8'h01);
    rd(2'd2, s); chk("t2_rearm_clears_done", s, 8'h03);
    wait_wr(base + 5, 5000, "t2_writes_started");
    wr(2'd1, 8'h01);
    wait_stat(8'h04, 8'h04, 5000, "t2_done_seen");
    rd(2'd2, s); chk("t2_status", s, 8'h05);
    chk_frame(base, "t2", 1);

    // One 99-clock line during capture
    base = wr_cnt;
    wr(2'd1, 8'h01);
    wait_wr(base + 2, 5000, "t3_writes_started");
    rd(2'd3, e1);
    short_cnt++;
    wait_stat(8'h08, 8'h08, 400, "t3_err_seen");
    rd(2'd2, s); chk("t3_status", s, 8'h08);
    rd(2'd3, s); chk("t3_errcnt", s, 8'(e1 + 1));
    w1 = wr_cnt;
    repeat (300) tick();
    chk("t3_writes_stopped", wr_cnt, w1);
    rd(2'd2, s); chk("t3_relock", s, 8'h09);

    // Early vsync during capture
    base = wr_cnt;
    wr(2'd1, 8'h01);
    rd(2'd2, s); chk("t4_arm_from_idle", s, 8'h0B);
    wait_wr(base + 2, 5000, "t4_writes_started");
    wr(2'd1, 8'h01);
    rd(2'd2, s); chk("t4_arm_in_cap", s, 8'h0B);
    rd(2'd3, e2);
    early_cnt++;
    wait_stat(8'h02, 8'h00, 2500, "t4_abort_seen");
    rd(2'd2, s); chk("t4_status", s, 8'h08);
    rd(2'd3, s); chk("t4_errcnt", s, 8'(e2 + 1));
    chk("t4_partial_frame", int'((wr_cnt - base) < NWR), 1);
    repeat (300) tick();

    // Reset mid-capture at byte 10
    wr(2'd1, 8'h01);
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      tick();
      if (buf_we === 1'b1 && buf_addr == 13'd10) found = 1;
    end
    chk("t5_byte10_seen", found, 1);
    rst = 1; #1;
    chk("t5_we_on_rst_clk", buf_we, 0);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      rd(vecs[i].ra, s);
      chk({"t5_", vecs[i].name}, s, vecs[i].exp);
    end
    chk("t5_buf_we", buf_we, 0);
    chk("t5_buf_addr", buf_addr, 0);
    chk("t5_buf_data", buf_data, 0);
    w_rst = wr_cnt;
    rst = 0;
    repeat (4000) tick();
    rd(2'd2, s); chk("t5_relock", s, 8'h01);
    chk("t5_no_stray_writes", wr_cnt, w_rst);
    base = wr_cnt;
    wr(2'd1, 8'h01);
    wait_stat(8'h04, 8'h04, 5000, "t5_done_seen");
    rd(2'd2, s); chk("t5_status", s, 8'h05);
    chk_frame(base, "t5", 1);

    // No sync at all: never locks, arm parks in WAIT
    sync_en = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    repeat (500) tick();
    rd(2'd2, s); chk("t6_unlocked", s, 8'h00);
    w1 = wr_cnt;
    wr(2'd1, 8'h01);
    repeat (2500) tick();
    rd(2'd2, s); chk("t6_stuck_wait", s, 8'h02);
    chk("t6_no_writes", wr_cnt, w1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
